// File: rtl/spi_slave_adc_emu_if.sv
// Signal bundle between the on-chip SPI master / sample source and the ADC emulator.
// The master modport drives the link and the sample handshake; the slave answers.
interface spi_slave_adc_emu_if;
    logic       cs_n;
    logic       sclk;
    logic       sdata;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       busy;
    logic       stale;
    logic       frame_done;
    logic       frame_err;

    modport master (
        output cs_n, sclk, sample_in, sample_valid,
        input  sdata, sample_ready, busy, stale, frame_done, frame_err
    );

    modport slave (
        input  cs_n, sclk, sample_in, sample_valid,
        output sdata, sample_ready, busy, stale, frame_done, frame_err
    );
endinterface

// File: rtl/spi_slave_adc_emu.sv
// Serial ADC emulator: answers a 16-fall cs_n/sclk frame with 3 zeros, an 8-bit
// sample MSB-first, then 5 zeros. Samples arrive through a one-deep holding register.
//
// state  | meaning
// IDLE   | cs_n high, waiting for a frame start
// ACTIVE | frame in progress, counting sclk falls and shifting data
module spi_slave_adc_emu (
    input  logic                clk,
    input  logic                n_rst,
    spi_slave_adc_emu_if.slave  bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state;
    logic [2:0] cs_sr;
    logic [2:0] sck_sr;
    logic [7:0] hold;
    logic       hold_full;
    logic [7:0] shreg;
    logic [7:0] last;
    logic [4:0] fcnt;
    logic [4:0] fcnt_inc;
    logic       overrun;
    logic       sdata_r;
    logic       stale_r;
    logic       done_r;
    logic       err_r;
    logic       cs_fall;
    logic       cs_rise;
    logic       sck_fall;
    logic       handshake;

    // [0],[1] synchronize, [2] holds the previous synced level for edge detection
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cs_sr  <= 3'b111;
            sck_sr <= 3'b111;
        end else begin
            cs_sr  <= {cs_sr[1:0], bus.cs_n};
            sck_sr <= {sck_sr[1:0], bus.sclk};
        end
    end

    assign cs_fall   = !cs_sr[1] && cs_sr[2];
    assign cs_rise   = cs_sr[1] && !cs_sr[2];
    assign sck_fall  = !sck_sr[1] && sck_sr[2] && !cs_sr[1];
    assign handshake = bus.sample_valid && !hold_full;

    always_comb begin
        fcnt_inc = fcnt + 5'd1;
        if (fcnt == 5'd17) begin
            fcnt_inc = 5'd17;
        end
    end

    function automatic logic data_bit(input logic [7:0] s, input logic [4:0] cnt);
        logic [4:0] idx;
        idx = 5'd11 - cnt;
        if (cnt >= 5'd4 && cnt <= 5'd11) begin
            return s[idx[2:0]];
        end
        return 1'b0;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            shreg     <= 8'h00;
            last      <= 8'h00;
            fcnt      <= 5'd0;
            overrun   <= 1'b0;
            sdata_r   <= 1'b0;
            stale_r   <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (handshake) begin
                hold      <= bus.sample_in;
                hold_full <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= ACTIVE;
                        fcnt    <= 5'd0;
                        overrun <= 1'b0;
                        sdata_r <= 1'b0;
                        if (hold_full) begin
                            shreg     <= hold;
                            last      <= hold;
                            hold_full <= 1'b0;
                            stale_r   <= 1'b0;
                        end else if (bus.sample_valid) begin
                            // bypass: the offered sample feeds this frame and hold stays empty
                            shreg     <= bus.sample_in;
                            last      <= bus.sample_in;
                            hold_full <= 1'b0;
                            stale_r   <= 1'b0;
                        end else begin
                            shreg   <= last;
                            stale_r <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        sdata_r <= 1'b0;
                        if (fcnt == 5'd16 && !overrun) begin
                            done_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        fcnt    <= fcnt_inc;
                        sdata_r <= data_bit(shreg, fcnt_inc);
                        if (fcnt_inc == 5'd17) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sdata        = sdata_r;
    assign bus.sample_ready = !hold_full;
    assign bus.busy         = (state == ACTIVE);
    assign bus.stale        = stale_r;
    assign bus.frame_done   = done_r;
    assign bus.frame_err    = err_r;
endmodule

// File: tb/tb_spi_slave_adc_emu.sv
// Bench for the ADC emulator: a master drives cs_n/sclk frames and samples sdata on
// sclk rises; a sample-queue reference model predicts the word, stale flag and end pulse.
module tb_spi_slave_adc_emu;
    logic clk;
    logic n_rst;

    spi_slave_adc_emu_if bus ();

    spi_slave_adc_emu dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model: one pending sample slot plus the last value sent
    bit         m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_last = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        check("ready", bus.sample_ready, !m_full);
        bus.sample_in    = v;
        bus.sample_valid = 1'b1;
        tick(1);
        bus.sample_valid = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = v;
        end
    endtask

    task automatic run_frame(input int nfalls, input bit bypass, input logic [7:0] bval);
        logic [7:0]  exp;
        bit          exp_stale;
        logic [15:0] cap;
        logic [15:0] mask;
        logic [15:0] exp_word;
        logic        extra;
        int          ndone;
        int          nerr;
        int          n;
        if (m_full) begin
            exp = m_hold; m_full = 1'b0; exp_stale = 1'b0;
        end else if (bypass) begin
            exp = bval; exp_stale = 1'b0;
        end else begin
            exp = m_last; exp_stale = 1'b1;
        end
        m_last = exp;
        cap    = 16'h0000;
        extra  = 1'b0;

        bus.cs_n = 1'b0;
        tick(2);
        check("busy_pre", bus.busy, 1'b0);
        if (bypass) begin
            bus.sample_in    = bval;
            bus.sample_valid = 1'b1;
        end
        tick(1);
        bus.sample_valid = 1'b0;
        check("busy_start", bus.busy, 1'b1);
        check("ready_start", bus.sample_ready, 1'b1);
        tick(3);
        for (int i = 1; i <= nfalls; i++) begin
            bus.sclk = 1'b0;
            tick(14);
            if (i <= 16) cap[16-i] = bus.sdata;
            else extra = extra | bus.sdata;
            bus.sclk = 1'b1;
            tick(12);
        end
        check("stale", bus.stale, exp_stale);

        bus.cs_n = 1'b1;
        ndone = 0;
        nerr  = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            ndone += int'(bus.frame_done);
            nerr  += int'(bus.frame_err);
        end
        check("frame_done", ndone, (nfalls == 16) ? 1 : 0);
        check("frame_err", nerr, (nfalls == 16) ? 0 : 1);
        check("busy_end", bus.busy, 1'b0);
        check("sdata_end", bus.sdata, 1'b0);

        n        = (nfalls > 16) ? 16 : nfalls;
        mask     = 16'hFFFF;
        mask     = mask << (16 - n);
        exp_word = {3'b000, exp, 5'b00000} & mask;
        check("data_word", cap, exp_word);
        if (nfalls > 16) check("overrun_tail", extra, 1'b0);
    endtask

    task automatic reset_mid_frame(input int nfalls);
        int np;
        bus.cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < nfalls; i++) begin
            bus.sclk = 1'b0;
            tick(14);
            bus.sclk = 1'b1;
            tick(12);
        end
        check("rst_busy_before", bus.busy, 1'b1);
        #3 n_rst = 1'b0;
        #1;
        check("rst_sdata", bus.sdata, 1'b0);
        check("rst_ready", bus.sample_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_stale", bus.stale, 1'b0);
        check("rst_done", bus.frame_done, 1'b0);
        check("rst_err", bus.frame_err, 1'b0);
        bus.cs_n = 1'b1;
        bus.sclk = 1'b1;
        m_full   = 1'b0;
        m_hold   = 8'h00;
        m_last   = 8'h00;
        tick(3);
        n_rst = 1'b1;
        np = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            np += int'(bus.frame_done) + int'(bus.frame_err);
        end
        check("rst_no_pulse", np, 0);
    endtask

    initial begin
        int sel;
        int nf;
        bit bp;
        n_rst            = 1'b0;
        bus.cs_n         = 1'b1;
        bus.sclk         = 1'b1;
        bus.sample_in    = 8'h00;
        bus.sample_valid = 1'b0;
        tick(3);
        check("reset_sdata", bus.sdata, 1'b0);
        check("reset_ready", bus.sample_ready, 1'b1);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_stale", bus.stale, 1'b0);
        check("reset_done", bus.frame_done, 1'b0);
        check("reset_err", bus.frame_err, 1'b0);
        n_rst = 1'b1;
        tick(3);

        push(8'hA5);
        run_frame(16, 1'b0, 8'h00);
        run_frame(16, 1'b0, 8'h00);
        push(8'h3C);
        push(8'hEE);
        run_frame(16, 1'b0, 8'h00);
        run_frame(16, 1'b1, 8'h81);
        push(8'h96);
        run_frame(7, 1'b0, 8'h00);
        run_frame(18, 1'b0, 8'h00);
        reset_mid_frame(6);
        push(8'h5A);
        run_frame(16, 1'b0, 8'h00);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) push(8'($urandom));
            if ($urandom_range(0, 3) == 0) push(8'($urandom));
            sel = $urandom_range(0, 3);
            if (sel < 2)       nf = 16;
            else if (sel == 2) nf = $urandom_range(1, 15);
            else               nf = $urandom_range(17, 19);
            bp = !m_full && ($urandom_range(0, 2) == 0);
            run_frame(nf, bp, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_slave_adc_emu.md
# spi_slave_adc_emu

Serial ADC emulator: the responder side of the team's 3-wire ADC read link (cs_n, sclk, sdata). It watches cs_n/sclk from an SPI master in the same FPGA, captures an 8-bit sample at frame start, and shifts it out MSB-first. The 16-clock frame is 3 leading zeros, 8 data bits, 5 trailing zeros. It lets the ADC read path be exercised on-chip without the physical converter.

## Interface
Parameters:
- none; frame format is fixed: 16 sclk falls, data on falls 4..11.

Ports:
- clk  in  1  system clock; cs_n and sclk are sampled on its rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- cs_n  in  1  chip select from master, active low, idles high.
- sclk  in  1  serial clock from master, idles high. Each low and high phase is at least 5 clk.
- sample_in  in  8  next sample value.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  holding register is empty; the transfer occurs when sample_valid && sample_ready.
- sdata  out  1  serial data to master.
- busy  out  1  frame in progress.
- stale  out  1  current or last frame re-sent the previous sample because no fresh sample was available.
- frame_done  out  1  one-cycle pulse: clean frame end.
- frame_err  out  1  one-cycle pulse: aborted or overrun frame.

## Operation
- Input conditioning: cs_n and sclk each pass through a 2-flop synchronizer (reset value 1), then a third register for edge detection.
  - cs_fall = sync 0 and prev 1; cs_rise = sync 1 and prev 0.
  - sck_fall is qualified by synced cs_n = 0.
- Holding register: hold[7:0] and hold_full flag.
  - sample_ready = !hold_full.
  - Handshake: hold <= sample_in, hold_full <= 1.
- Frame start, on cs_fall:
  - If hold_full: shreg <= hold, hold_full <= 0, stale <= 0.
  - Else if sample_valid: bypass, shreg <= sample_in, stale <= 0, hold stays empty, handshake counts as consumed.
  - Else: shreg <= last sent value (last), stale <= 1.
  - In all cases: last <= loaded value, fcnt <= 0, busy <= 1, overrun <= 0.
- On each sck_fall:
  - fcnt <= fcnt + 1, 5-bit, saturating at 17.
  - If fcnt reaches 17, set overrun.
- sdata, registered:
  - 0 while busy = 0.
  - shreg[11 - fcnt] while fcnt is 4..11; bit 7 goes out after the 4th fall, bit 0 after the 11th fall.
  - 0 for every other fcnt value.
- Frame end, on cs_rise while busy: busy <= 0, sdata <= 0.
  - frame_done pulses if fcnt == 16 and !overrun.
  - Otherwise frame_err pulses.
  - A cs_rise while idle is ignored.
- States, implied by busy: IDLE to ACTIVE on cs_fall; ACTIVE to IDLE on cs_rise. A cs_fall while ACTIVE cannot occur without an intervening cs_rise.

## Timing
- Reset values: sdata 0, sample_ready 1, busy 0, stale 0, frame_done 0, frame_err 0, hold/shreg/last 0, fcnt 0.
- Latency from pin edge to registered response is 3 clk. A cs_n fall at edge t gives busy = 1 after edge t+3. An sclk fall gives the sdata update after edge t+3.
- Data setup: the master samples on the sclk rise. sdata is stable ≥ 2 clk before that rise, given the ≥5 clk low phase.
- frame_done/frame_err fire 3 clk after the cs_n rise and last exactly 1 cycle.
- sclk edges while cs_n is high are ignored. The sclk level at cs_fall does not matter.
- Asynchronous reset mid-frame: all state returns to reset values immediately and no pulse is produced. The frame is resumed only by a fresh cs_n fall.
- Handshake and frame-start load in the same cycle with hold_full = 1: the load takes the old hold, and the new sample is not accepted because sample_ready = 0.

## Test plan
- Clean frame: load 0xA5, then send cs_n low, 16 sclk periods (12 clk high, 14 clk low), cs_n high. The master-side shift of rise samples 4..11 must read 0xA5; sdata is 0 on all other rises; frame_done = 1 once; stale = 0.
- Stale resend: after the 0xA5 frame, run a frame with no sample -> receives 0xA5 again, stale = 1. Then load 0x3C -> next frame receives 0x3C, stale = 0.
- Bypass: sample_valid with 0x81 in the same cycle as the synced cs_fall, hold empty -> frame returns 0x81; sample_ready stays 1.
- Abort: cs_n rises after 7 falls -> frame_err = 1, sdata 0, busy 0, no frame_done.
- Overrun: 18 falls before cs_n rises -> sdata 0 after the 11th fall, frame_err = 1.
- Reset mid-frame: n_rst low after 6 falls -> all outputs at reset values, no pulse. The next full frame with 0x5A is received correctly.
